voice_allocator: RTL and testbench



---
 rtl/voice_allocator.sv | 225 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphony scheduler between the PS/2 key decoder and the synth voice bank.
//   Once per frame it snapshots the 32-bit key-held vector, then walks the keys
//   in ascending order (one key per clock). Each newly pressed key gets a voice:
//   the lowest-index free voice, or, when every voice is busy, the oldest voice
//   (largest age, lowest index on ties). Each released key frees the voice or
//   voices still holding it. Every allocation or release produces a one-cycle
//   event strobe.
//
//   Frame: SNAP (1 cycle) + SCAN (NUM_KEYS cycles) + DONE (1 cycle).
//
// Ports
//   i_clk_100k    system clock
//   i_rst_n       asynchronous active-low reset
//   i_key         key-held vector, bit i = key i held
//   i_enable      allow a new scan frame to start
//   o_voice_gate  per-voice gate (voice v sounding)
//   o_voice_key   per-voice key index, voice v at [v*KEY_W +: KEY_W]
//   o_evt_valid   one-cycle event strobe
//   o_evt_on      1 = note-on, 0 = note-off
//   o_evt_steal   note-on replaced an active voice
//   o_evt_voice   voice index of the event
//   o_evt_key     key index of the event
//   o_busy        scan frame in progress
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 32,
  parameter int KEY_W      = 5,
  parameter int AGE_W      = 4
) (
  input  logic                        i_clk_100k,
  input  logic                        i_rst_n,
  input  logic [NUM_KEYS-1:0]         i_key,
  input  logic                        i_enable,
  output logic [NUM_VOICES-1:0]       o_voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
  output logic                        o_evt_valid,
  output logic                        o_evt_on,
  output logic                        o_evt_steal,
  output logic [2:0]                  o_evt_voice,
  output logic [KEY_W-1:0]            o_evt_key,
  output logic                        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Saturating age increment: an age that reaches all-ones stays there.
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  state_t                  state_q;
  state_t                  state_d;
  logic [NUM_KEYS-1:0]     cur_r;
  logic [NUM_KEYS-1:0]     prev_r;
  logic [KEY_W-1:0]        idx_r;

  logic [NUM_VOICES-1:0]   gate_r;
  logic [KEY_W-1:0]        key_r [NUM_VOICES];
  logic [AGE_W-1:0]        age_r [NUM_VOICES];

  // Stage p0: decisions for the key under scan, from current voice state.
  logic                    press_p0;
  logic                    release_p0;
  logic                    any_free_p0;
  logic [2:0]              free_idx_p0;
  logic [2:0]              old_idx_p0;
  logic [AGE_W-1:0]        old_age_p0;
  logic [2:0]              chosen_p0;
  logic                    match_any_p0;
  logic [2:0]              match_idx_p0;

  // Stage p1: registered event, aligned with the voice-state update.
  logic                    vld_p1;
  logic                    evt_on_p1;
  logic                    evt_steal_p1;
  logic [2:0]              evt_voice_p1;
  logic [KEY_W-1:0]        evt_key_p1;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_enable) state_d = SNAP;
      SNAP: state_d = SCAN;
      SCAN: if (idx_r == KEY_W'(NUM_KEYS - 1)) state_d = DONE;
      DONE: state_d = i_enable ? SNAP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_r  <= '0;
      prev_r <= '0;
      idx_r  <= '0;
    end else begin
      case (state_q)
        SNAP: begin
          cur_r <= i_key;
          idx_r <= '0;
        end
        SCAN: if (idx_r != KEY_W'(NUM_KEYS - 1)) idx_r <= idx_r + 1'b1;
        DONE: prev_r <= cur_r;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- stage p0
  always_comb begin
    press_p0     = (state_q == SCAN) && cur_r[idx_r] && !prev_r[idx_r];
    release_p0   = (state_q == SCAN) && !cur_r[idx_r] && prev_r[idx_r];

    // Descending walk so the last hit is the lowest index.
    any_free_p0  = 1'b0;
    free_idx_p0  = '0;
    match_any_p0 = 1'b0;
    match_idx_p0 = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!gate_r[v]) begin
        any_free_p0 = 1'b1;
        free_idx_p0 = 3'(v);
      end
      if (gate_r[v] && (key_r[v] == idx_r)) begin
        match_any_p0 = 1'b1;
        match_idx_p0 = 3'(v);
      end
    end

    // Ascending walk with strict '>' keeps the lowest index on age ties.
    old_idx_p0 = '0;
    old_age_p0 = age_r[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_r[v] > old_age_p0) begin
        old_age_p0 = age_r[v];
        old_idx_p0 = 3'(v);
      end
    end

    chosen_p0 = any_free_p0 ? free_idx_p0 : old_idx_p0;
  end

  // ---------------------------------------------------------------- stage p1
  always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gate_r <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_r[v] <= '0;
        age_r[v] <= '0;
      end
    end else if (press_p0) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (3'(v) == chosen_p0) begin
          gate_r[v] <= 1'b1;
          key_r[v]  <= idx_r;
          age_r[v]  <= '0;
        end else if (gate_r[v]) begin
          age_r[v]  <= sat_inc(age_r[v]);
        end
      end
    end else if (release_p0) begin
      // A key whose voice was stolen matches nothing and changes nothing.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (gate_r[v] && (key_r[v] == idx_r)) begin
          gate_r[v] <= 1'b0;
          age_r[v]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1       <= 1'b0;
      evt_on_p1    <= 1'b0;
      evt_steal_p1 <= 1'b0;
      evt_voice_p1 <= '0;
      evt_key_p1   <= '0;
    end else begin
      vld_p1 <= press_p0 || (release_p0 && match_any_p0);
      // Event fields hold their last values between strobes.
      if (press_p0) begin
        evt_on_p1    <= 1'b1;
        evt_steal_p1 <= !any_free_p0;
        evt_voice_p1 <= chosen_p0;
        evt_key_p1   <= idx_r;
      end else if (release_p0 && match_any_p0) begin
        evt_on_p1    <= 1'b0;
        evt_steal_p1 <= 1'b0;
        evt_voice_p1 <= match_idx_p0;
        evt_key_p1   <= idx_r;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      o_voice_key[v*KEY_W +: KEY_W] = key_r[v];
    end
  end

  assign o_voice_gate = gate_r;
  assign o_evt_valid  = vld_p1;
  assign o_evt_on     = evt_on_p1;
  assign o_evt_steal  = evt_steal_p1;
  assign o_evt_voice  = evt_voice_p1;
  assign o_evt_key    = evt_key_p1;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Directed bench for voice_allocator. Instance u_dut uses the default
//   parameters; instance u_dut_a1 is built with AGE_W = 1 so ages saturate
//   after one step and ties on the maximum age are common.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 5;

  logic              clk = 1'b0;
  logic              rst_n;

  logic [31:0]       key0;
  logic              en0;
  logic [NV-1:0]     gate0;
  logic [NV*KW-1:0]  vkey0;
  logic              valid0, on0, steal0, busy0;
  logic [2:0]        voice0;
  logic [KW-1:0]     ekey0;

  logic [31:0]       key1;
  logic              en1;
  logic [NV-1:0]     gate1;
  logic [NV*KW-1:0]  vkey1;
  logic              valid1, on1, steal1, busy1;
  logic [2:0]        voice1;
  logic [KW-1:0]     ekey1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic              ev_on, ev_steal;
  logic [2:0]        ev_voice;
  logic [KW-1:0]     ev_key;
  logic [NV-1:0]     ev_gate;
  logic [NV*KW-1:0]  ev_vkey;
  int                ev_cyc;

  voice_allocator #(.NUM_VOICES(NV), .NUM_KEYS(32), .KEY_W(KW), .AGE_W(4)) u_dut (
    .i_clk_100k   (clk),
    .i_rst_n      (rst_n),
    .i_key        (key0),
    .i_enable     (en0),
    .o_voice_gate (gate0),
    .o_voice_key  (vkey0),
    .o_evt_valid  (valid0),
    .o_evt_on     (on0),
    .o_evt_steal  (steal0),
    .o_evt_voice  (voice0),
    .o_evt_key    (ekey0),
    .o_busy       (busy0)
  );

  voice_allocator #(.NUM_VOICES(NV), .NUM_KEYS(32), .KEY_W(KW), .AGE_W(1)) u_dut_a1 (
    .i_clk_100k   (clk),
    .i_rst_n      (rst_n),
    .i_key        (key1),
    .i_enable     (en1),
    .o_voice_gate (gate1),
    .o_voice_key  (vkey1),
    .o_evt_valid  (valid1),
    .o_evt_on     (on1),
    .o_evt_steal  (steal1),
    .o_evt_voice  (voice1),
    .o_evt_key    (ekey1),
    .o_busy       (busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next strobe of the selected instance and
  // captures the event fields and voice outputs seen in that cycle.
  task automatic wait_evt(input int which, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (which == 0 && valid0) begin
        got = 1'b1;
        ev_on = on0; ev_steal = steal0; ev_voice = voice0; ev_key = ekey0;
        ev_gate = gate0; ev_vkey = vkey0; ev_cyc = cyc;
      end else if (which == 1 && valid1) begin
        got = 1'b1;
        ev_on = on1; ev_steal = steal1; ev_voice = voice1; ev_key = ekey1;
        ev_gate = gate1; ev_vkey = vkey1; ev_cyc = cyc;
      end
    end
    chk({tag, "_seen"}, 32'(got), 1);
  endtask

  task automatic count_evts(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (valid0) n++;
    end
  endtask

  task automatic chk_evt(input string tag, input int on, input int steal,
                         input int voice, input int key);
    chk({tag, "_on"},    32'(ev_on),    32'(on));
    chk({tag, "_steal"}, 32'(ev_steal), 32'(steal));
    chk({tag, "_voice"}, 32'(ev_voice), 32'(voice));
    chk({tag, "_key"},   32'(ev_key),   32'(key));
  endtask

  initial begin
    int nb;
    int n;
    int t0;
    int c0;

    rst_n = 1'b0;
    en0 = 1'b0; key0 = '0;
    en1 = 1'b0; key1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_gate",  32'(gate0), 0);
    chk("rst_vkey",  32'(vkey0), 0);
    chk("rst_evt",   32'({valid0, on0, steal0, voice0, ekey0}), 0);
    chk("rst_busy",  32'(busy0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // One enable pulse from IDLE runs exactly one 34-cycle frame
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy0) nb++;
      @(negedge clk);
    end
    chk("frame_len", 32'(nb), 34);

    // Free-running with no keys: no events, no gates
    en0 = 1'b1;
    count_evts(80, n);
    chk("idle_no_evt", 32'(n), 0);
    chk("idle_gate",   32'(gate0), 0);
    chk("run_busy",    32'(busy0), 1);

    // Single press / release of key 5
    key0 = 32'h0000_0020;
    wait_evt(0, "k5_on");
    chk_evt("k5_on", 1, 0, 0, 5);
    chk("k5_on_gate", 32'(ev_gate), 32'h1);
    chk("k5_on_vkey0", 32'(ev_vkey[4:0]), 5);
    @(negedge clk);
    chk("k5_strobe_len", 32'(valid0), 0);
    key0 = '0;
    wait_evt(0, "k5_off");
    chk_evt("k5_off", 0, 0, 0, 5);
    chk("k5_off_gate", 32'(ev_gate), 0);

    // Keys 3 and 10 in one snapshot: ascending order, 7 cycles apart
    key0 = (32'h1 << 3) | (32'h1 << 10);
    wait_evt(0, "k3_on");
    t0 = ev_cyc;
    chk_evt("k3_on", 1, 0, 0, 3);
    wait_evt(0, "k10_on");
    chk_evt("k10_on", 1, 0, 1, 10);
    chk("k3_k10_gap", 32'(ev_cyc - t0), 7);
    chk("k10_vkey0", 32'(ev_vkey[4:0]), 3);
    chk("k10_vkey1", 32'(ev_vkey[9:5]), 10);
    chk("k10_gate",  32'(ev_gate), 32'h3);
    key0 = '0;
    wait_evt(0, "k3_off");
    chk_evt("k3_off", 0, 0, 0, 3);
    wait_evt(0, "k10_off");
    chk_evt("k10_off", 0, 0, 1, 10);
    chk("k10_off_gate", 32'(ev_gate), 0);

    // Keys 1..4 in separate frames, then key 6 steals the oldest (voice 0)
    key0 = 32'h02; wait_evt(0, "p1");
    key0 = 32'h06; wait_evt(0, "p2");
    key0 = 32'h0E; wait_evt(0, "p3");
    key0 = 32'h1E; wait_evt(0, "p4");
    chk_evt("p4", 1, 0, 3, 4);
    chk("p4_gate", 32'(ev_gate), 32'hF);
    key0 = 32'h5E;
    wait_evt(0, "steal6");
    chk_evt("steal6", 1, 1, 0, 6);
    chk("steal6_vkey0", 32'(ev_vkey[4:0]), 6);
    chk("steal6_gate",  32'(ev_gate), 32'hF);

    // Releasing the stolen key 1 produces nothing
    key0 = 32'h5C;
    count_evts(80, n);
    chk("rel_stolen_no_evt", 32'(n), 0);
    chk("rel_stolen_gate",   32'(gate0), 32'hF);

    // Release everything: keys 2,3,4,6 on voices 1,2,3,0
    key0 = '0;
    wait_evt(0, "r2");
    chk_evt("r2", 0, 0, 1, 2);
    wait_evt(0, "r3");
    wait_evt(0, "r4");
    wait_evt(0, "r6");
    chk_evt("r6", 0, 0, 0, 6);
    chk("rall_gate", 32'(ev_gate), 0);

    // Enable dropped at scan index 10 while key 20 is newly pressed
    en0 = 1'b0;
    for (int i = 0; i < 50 && busy0; i++) @(negedge clk);
    chk("idle_before_drop", 32'(busy0), 0);
    @(negedge clk);
    key0 = 32'h1 << 20;
    en0  = 1'b1;
    c0   = cyc;
    repeat (12) @(negedge clk);
    en0 = 1'b0;
    wait_evt(0, "k20_on");
    chk_evt("k20_on", 1, 0, 0, 20);
    chk("k20_latency", 32'(ev_cyc - c0), 23);
    repeat (20) @(negedge clk);
    chk("drop_idle", 32'(busy0), 0);
    chk("drop_gate_hold", 32'(gate0), 32'h1);

    // Asynchronous reset in mid-frame
    key0 = (32'h1 << 20) | (32'h1 << 21);
    en0  = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 32'(busy0), 1);
    chk("pre_rst_gate", 32'(gate0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate", 32'(gate0), 0);
    chk("arst_vkey", 32'(vkey0), 0);
    chk("arst_evt",  32'({valid0, on0, steal0, voice0, ekey0}), 0);
    chk("arst_busy", 32'(busy0), 0);
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_no_off_evt", 32'(valid0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // AGE_W = 1: five presses in one snapshot, then key 7 hits an age tie
    key1 = 32'h3E;
    en1  = 1'b1;
    wait_evt(1, "a1_k1");
    chk_evt("a1_k1", 1, 0, 0, 1);
    wait_evt(1, "a1_k2");
    chk_evt("a1_k2", 1, 0, 1, 2);
    wait_evt(1, "a1_k3");
    wait_evt(1, "a1_k4");
    chk_evt("a1_k4", 1, 0, 3, 4);
    wait_evt(1, "a1_k5");
    chk_evt("a1_k5", 1, 1, 0, 5);
    key1 = 32'hBE;
    wait_evt(1, "a1_k7");
    chk_evt("a1_k7", 1, 1, 1, 7);
    chk("a1_k7_gate",  32'(ev_gate), 32'hF);
    chk("a1_k7_vkey1", 32'(ev_vkey[9:5]), 7);
    en1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
